// File: rtl/semi_auto_pkg.sv
// Shared types and constants for the semi-automatic driving controller.
// Detector bit order and the junction rule live here so every user agrees on them.
package semi_auto_pkg;

    typedef enum logic [2:0] {
        STOP,
        TURN_REQ,
        TURNING,
        LEAVE,
        CRUISE
    } state_t;

    localparam int unsigned DET_FRONT = 3;
    localparam int unsigned DET_BACK  = 2;
    localparam int unsigned DET_LEFT  = 1;
    localparam int unsigned DET_RIGHT = 0;

    // A junction is any place where the car cannot simply keep driving down a corridor.
    function automatic logic is_junction(input logic [3:0] det);
        return det[DET_FRONT] | ~det[DET_LEFT] | ~det[DET_RIGHT];
    endfunction

endpackage

// File: rtl/rise_detect.sv
// One-bit rising-edge detector.
// Keeps the previous sample in a register and flags the cycle where the input first goes high.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/semi_auto.sv
// Semi-automatic driving controller: drives along corridors, stops at junctions,
// and executes user-chosen turns through the turn unit's is_turning handshake.
module semi_auto
    import semi_auto_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       is_turning,
    input  logic       move_forward,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       move_backward,
    input  logic [3:0] detector,
    output logic       out_move_forward,
    output logic       trigger_turn_left,
    output logic       trigger_turn_right,
    output logic       trigger_turn_back
);

    logic fwd_edge, left_edge, right_edge, back_edge;

    rise_detect u_fwd_edge   (.clk(clk), .rst(rst), .d(move_forward),  .rise(fwd_edge));
    rise_detect u_left_edge  (.clk(clk), .rst(rst), .d(move_left),     .rise(left_edge));
    rise_detect u_right_edge (.clk(clk), .rst(rst), .d(move_right),    .rise(right_edge));
    rise_detect u_back_edge  (.clk(clk), .rst(rst), .d(move_backward), .rise(back_edge));

    state_t state, state_nxt;
    logic   fwd_nxt, left_nxt, right_nxt, back_nxt;
    logic   junction;

    assign junction = is_junction(detector);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= STOP;
            out_move_forward   <= 1'b0;
            trigger_turn_left  <= 1'b0;
            trigger_turn_right <= 1'b0;
            trigger_turn_back  <= 1'b0;
        end else begin
            state              <= state_nxt;
            out_move_forward   <= fwd_nxt;
            trigger_turn_left  <= left_nxt;
            trigger_turn_right <= right_nxt;
            trigger_turn_back  <= back_nxt;
        end
    end

    // Outputs are decided from the next state so they land one cycle after the sampled edge.
    always_comb begin
        state_nxt = state;
        left_nxt  = 1'b0;
        right_nxt = 1'b0;
        back_nxt  = 1'b0;

        unique case (state)
            STOP: begin
                if (fwd_edge && !detector[DET_FRONT]) begin
                    state_nxt = LEAVE;
                end else if (left_edge && !detector[DET_LEFT]) begin
                    state_nxt = TURN_REQ;
                    left_nxt  = 1'b1;
                end else if (right_edge && !detector[DET_RIGHT]) begin
                    state_nxt = TURN_REQ;
                    right_nxt = 1'b1;
                end else if (back_edge && !detector[DET_BACK]) begin
                    state_nxt = TURN_REQ;
                    back_nxt  = 1'b1;
                end
            end
            TURN_REQ: begin
                if (is_turning) begin
                    state_nxt = TURNING;
                end
            end
            TURNING: begin
                if (!is_turning) begin
                    state_nxt = LEAVE;
                end
            end
            LEAVE: begin
                if (detector[DET_FRONT]) begin
                    state_nxt = STOP;
                end else if (!junction) begin
                    state_nxt = CRUISE;
                end
            end
            CRUISE: begin
                if (junction) begin
                    state_nxt = STOP;
                end
            end
            default: state_nxt = STOP;
        endcase

        if (!enable) begin
            state_nxt = STOP;
            left_nxt  = 1'b0;
            right_nxt = 1'b0;
            back_nxt  = 1'b0;
        end

        fwd_nxt = (state_nxt == LEAVE) || (state_nxt == CRUISE);
    end

endmodule

// File: tb/tb_semi_auto.sv
// Directed bench for semi_auto: a behavioural car-controller model checked every cycle,
// plus hand-computed expectations along a scripted drive.
module tb_semi_auto;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       is_turning = 1'b0;
    logic       move_forward = 1'b0;
    logic       move_left = 1'b0;
    logic       move_right = 1'b0;
    logic       move_backward = 1'b0;
    logic [3:0] detector = 4'b0000;
    logic       out_move_forward;
    logic       trigger_turn_left;
    logic       trigger_turn_right;
    logic       trigger_turn_back;

    int total = 0;
    int bad = 0;

    semi_auto dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .is_turning(is_turning),
        .move_forward(move_forward),
        .move_left(move_left),
        .move_right(move_right),
        .move_backward(move_backward),
        .detector(detector),
        .out_move_forward(out_move_forward),
        .trigger_turn_left(trigger_turn_left),
        .trigger_turn_right(trigger_turn_right),
        .trigger_turn_back(trigger_turn_back)
    );

    always #10 clk = ~clk;

    // Behavioural model: activity of the car, not controller states.
    localparam int PARKED = 0, AWAIT_TURN = 1, IN_TURN = 2, EXITING = 3, DRIVING = 4;
    int         activity = PARKED;
    logic [3:0] prev_cmd = 4'b0000;
    logic       e_fwd = 1'b0, e_left = 1'b0, e_right = 1'b0, e_back = 1'b0;

    always @(posedge clk or posedge rst) begin
        logic [3:0] cmd, edges;
        int         pick;
        int         guard_bit[4];
        guard_bit = '{3, 1, 0, 2};  // forward, left, right, back -> detector bit guarding each
        if (rst) begin
            activity = PARKED;
            prev_cmd = 4'b0000;
            e_fwd = 1'b0; e_left = 1'b0; e_right = 1'b0; e_back = 1'b0;
        end else begin
            cmd = {move_backward, move_right, move_left, move_forward};
            edges = cmd & ~prev_cmd;
            prev_cmd = cmd;
            e_left = 1'b0; e_right = 1'b0; e_back = 1'b0;
            if (!enable) begin
                activity = PARKED;
            end else if (activity == PARKED) begin
                pick = -1;
                for (int i = 0; i < 4; i++)
                    if (pick < 0 && edges[i] && !detector[guard_bit[i]]) pick = i;
                if (pick == 0) activity = EXITING;
                else if (pick > 0) begin
                    activity = AWAIT_TURN;
                    e_left = (pick == 1); e_right = (pick == 2); e_back = (pick == 3);
                end
            end else if (activity == AWAIT_TURN) begin
                if (is_turning) activity = IN_TURN;
            end else if (activity == IN_TURN) begin
                if (!is_turning) activity = EXITING;
            end else if (activity == EXITING) begin
                if (detector[3]) activity = PARKED;
                else if (detector[1] && detector[0]) activity = DRIVING;
            end else begin
                if (detector[3] || !detector[1] || !detector[0]) activity = PARKED;
            end
            e_fwd = (activity == EXITING) || (activity == DRIVING);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if ({out_move_forward, trigger_turn_left, trigger_turn_right, trigger_turn_back} !==
                {e_fwd, e_left, e_right, e_back}) begin
                bad++;
                $display("FAIL model_cmp t=%0t got fwd/l/r/b=%b%b%b%b want %b%b%b%b", $time,
                         out_move_forward, trigger_turn_left, trigger_turn_right, trigger_turn_back,
                         e_fwd, e_left, e_right, e_back);
            end
            total++;
            if (32'(trigger_turn_left) + 32'(trigger_turn_right) + 32'(trigger_turn_back) > 1) begin
                bad++;
                $display("FAIL one_trigger t=%0t got l/r/b=%b%b%b want at most one high", $time,
                         trigger_turn_left, trigger_turn_right, trigger_turn_back);
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got %b want %b", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        chk("reset_fwd", out_move_forward, 1'b0);
        chk("reset_left", trigger_turn_left, 1'b0);
        chk("reset_right", trigger_turn_right, 1'b0);
        chk("reset_back", trigger_turn_back, 1'b0);

        // Disabled: commands have no effect.
        detector = 4'b0011;
        move_forward = 1'b1; tick(1);
        move_forward = 1'b0;
        chk("disabled_fwd", out_move_forward, 1'b0);
        tick(1);

        // Forward then cruise, stop at blocked front.
        enable = 1'b1; tick(1);
        move_forward = 1'b1; tick(1);
        move_forward = 1'b0;
        chk("fwd_leave", out_move_forward, 1'b1);
        tick(1);
        chk("fwd_cruise", out_move_forward, 1'b1);
        detector = 4'b1001; tick(1);
        chk("cruise_stop", out_move_forward, 1'b0);

        // Left turn with is_turning rising together with the command.
        move_left = 1'b1; is_turning = 1'b1; tick(1);
        chk("left_pulse", trigger_turn_left, 1'b1);
        move_left = 1'b0; detector = 4'b0011; tick(1);
        chk("left_pulse_end", trigger_turn_left, 1'b0);
        chk("left_turning_fwd", out_move_forward, 1'b0);
        is_turning = 1'b0; tick(1);
        chk("left_leave", out_move_forward, 1'b1);
        tick(1);
        chk("left_cruise", out_move_forward, 1'b1);
        detector = 4'b1000; tick(1);
        chk("left_stop", out_move_forward, 1'b0);

        // Right turn at 1000.
        move_right = 1'b1; tick(1);
        chk("right_pulse", trigger_turn_right, 1'b1);
        move_right = 1'b0; is_turning = 1'b1; tick(1);
        is_turning = 1'b0; tick(1);
        chk("right_leave", out_move_forward, 1'b1);
        tick(1);
        chk("right_front_stop", out_move_forward, 1'b0);

        // Back turn at 1011 with a 40 ns turn.
        detector = 4'b1011;
        move_backward = 1'b1; tick(1);
        chk("back_pulse", trigger_turn_back, 1'b1);
        move_backward = 1'b0; is_turning = 1'b1; tick(1);
        chk("back_turn_hold1", out_move_forward, 1'b0);
        tick(1);
        chk("back_turn_hold2", out_move_forward, 1'b0);
        is_turning = 1'b0; tick(1);
        chk("back_leave", out_move_forward, 1'b1);
        tick(1);
        chk("back_front_stop", out_move_forward, 1'b0);

        // Blocked right ignored, then left with is_turning 5 ns later.
        detector = 4'b1001;
        move_right = 1'b1; tick(1);
        chk("blocked_right", trigger_turn_right, 1'b0);
        move_right = 1'b0;
        move_left = 1'b1;
        #5 is_turning = 1'b1;
        tick(1);
        chk("late_turn_left", trigger_turn_left, 1'b1);
        move_left = 1'b0; detector = 4'b0011; tick(1);
        is_turning = 1'b0; tick(1);
        chk("late_leave", out_move_forward, 1'b1);
        tick(1);
        chk("late_cruise", out_move_forward, 1'b1);
        detector = 4'b0001; tick(1);
        chk("left_open_stop", out_move_forward, 1'b0);

        // Simultaneous edges: forward blocked, left beats right.
        detector = 4'b1001;
        move_forward = 1'b1; move_left = 1'b1; move_right = 1'b1; tick(1);
        chk("simul_left", trigger_turn_left, 1'b1);
        chk("simul_right", trigger_turn_right, 1'b0);
        move_forward = 1'b0; move_left = 1'b0; move_right = 1'b0; is_turning = 1'b1; tick(1);
        is_turning = 1'b0; detector = 4'b0011; tick(1);
        chk("simul_leave", out_move_forward, 1'b1);
        tick(1);
        move_left = 1'b1; tick(1);
        chk("cruise_cmd_ignored", trigger_turn_left, 1'b0);
        move_left = 1'b0;

        // Asynchronous reset mid-cruise.
        #3 rst = 1'b1;
        #1 chk("async_rst_fwd", out_move_forward, 1'b0);
        tick(1);
        rst = 1'b0;
        move_forward = 1'b1; tick(1);
        move_forward = 1'b0;
        chk("post_rst_leave", out_move_forward, 1'b1);
        tick(1);

        // Disable mid-cruise, then re-enable into STOP.
        enable = 1'b0; tick(1);
        chk("disable_fwd", out_move_forward, 1'b0);
        tick(1);
        enable = 1'b1; tick(2);
        chk("reenable_stop", out_move_forward, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/semi_auto.md
Name: semi_auto

Overview:
- Semi-automatic driving controller for the simulated car.
- Drives forward on its own along corridors and stops at junctions or dead ends.
- At a stop, waits for a user direction command, checks that direction against the obstacle detector, and issues a one-cycle turn trigger to the turning unit.
- Tracks the turn through the `is_turning` handshake, then resumes forward motion.
- Sits between the user-input decoder and the motion/turn unit.

Parameters:
- None (detector bit order and state codes are package constants).

Ports:
- clk  in  1  system clock (nominally 500 Hz)
- rst  in  1  asynchronous, active-high reset
- enable  in  1  mode select; 0 = block idle, all outputs 0
- is_turning  in  1  high while the turn unit executes a turn
- move_forward  in  1  user command (level; rising edge acts)
- move_left  in  1  user command (level; rising edge acts)
- move_right  in  1  user command (level; rising edge acts)
- move_backward  in  1  user command (level; rising edge acts)
- detector  in  4  obstacle flags, 1 = blocked: [3]=front, [2]=back, [1]=left, [0]=right
- out_move_forward  out  1  level; car drives forward while high
- trigger_turn_left  out  1  one-cycle pulse
- trigger_turn_right  out  1  one-cycle pulse
- trigger_turn_back  out  1  one-cycle pulse

Behaviour:
- All outputs are registered.
- Reset (asynchronous): state=STOP, all outputs 0, edge-detect history cleared.
- enable=0 acts as a synchronous reset to STOP: all outputs 0 and command edges ignored. When enable rises, the block starts in STOP.
- Command edge: cmd & ~cmd_q, sampled each clk. A trigger or drive output appears on the cycle after the edge is sampled (1-cycle latency).
- junction = detector[3] | ~detector[1] | ~detector[0], i.e. front blocked or either side open.
- States:
  - STOP: out_move_forward=0. Accept edges with priority forward > left > right > back.
    - forward accepted only if detector[3]=0 -> LEAVE.
    - left only if detector[1]=0 -> pulse trigger_turn_left, go to TURN_REQ.
    - right only if detector[0]=0 -> pulse trigger_turn_right, go to TURN_REQ.
    - back only if detector[2]=0 -> pulse trigger_turn_back, go to TURN_REQ.
    - A blocked command is ignored: no pulse, stay in STOP.
  - TURN_REQ: outputs 0; wait for is_turning=1, then -> TURNING. If is_turning is already high on entry, advance on the next cycle.
  - TURNING: outputs 0; wait for is_turning=0 -> LEAVE. Commands are ignored.
  - LEAVE: out_move_forward=1; ignore side openings while exiting the junction.
    - detector[3]=1 -> STOP.
    - ~junction -> CRUISE.
  - CRUISE: out_move_forward=1; junction -> STOP on the next cycle.
- Commands arriving outside STOP are discarded, not queued.
- Simultaneous command edges: only the highest-priority allowed command acts.
- Triggers are never high for more than one cycle, and at most one is high at a time.

Decomposition:
- Package semi_auto_pkg:
  - state enum {STOP, TURN_REQ, TURNING, LEAVE, CRUISE}
  - detector index constants DET_FRONT=3, DET_BACK=2, DET_LEFT=1, DET_RIGHT=0
- Sub-module rise_detect: one-bit registered rising-edge detector with async reset. Instantiate four times, once per command.

Test Plan:
- Disabled: enable=0, move_forward pulse, detector=0011 -> all outputs stay 0.
- Forward/cruise: enable=1, detector=0011, move_forward pulse -> out_move_forward=1 one cycle after edge. Then detector=1001 -> out_move_forward=0 next cycle.
- Left turn: at 1001, move_left with is_turning rising together -> single-cycle trigger_turn_left. is_turning falls, then detector=0011 -> out_move_forward=1 (LEAVE then CRUISE).
- Right and back:
  - At 1000, move_right -> trigger_turn_right pulse.
  - At 1011, move_backward -> trigger_turn_back pulse; is_turning held 40 ns -> no forward until it falls.
- Blocking: at 1001, move_right -> no trigger. Then move_left, is_turning 5 ns later -> trigger_turn_left, normal resume. Then detector=0001 -> stop.
- Reset/disable mid-cruise: rst or enable=0 while out_move_forward=1 -> outputs 0 immediately (rst) or next cycle (enable); state returns to STOP.
